// File: rtl/core_pkg.sv
// Shared definitions for the fetch stage: the state encoding, the datapath widths,
// the program counter step and the NOP word.
package core_pkg;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_FULL
  } fetch_state_t;

  localparam int INSTR_W = 32;
  localparam int IMM_W   = 16;
  localparam logic [INSTR_W-1:0] PC_STEP   = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/estagio_busca_if_id_reg.sv
// IF/ID pipeline register. It can load a new word, hold its value, or be cleared.
// A clear only drops valid; the stale word it leaves behind is never consumed.
module if_id_reg
  import core_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] new_instr,
  input  logic [INSTR_W-1:0] new_pc4,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] pc4,
  output logic [IMM_W-1:0]   imm
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc4   <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= new_instr;
      pc4   <= new_pc4;
    end
  end

  assign imm = instr[IMM_W-1:0];

endmodule

// File: rtl/estagio_busca.sv
// Instruction fetch stage: owns the pc, talks req/ack to instruction memory and feeds IF/ID.
// Optional macro DELAY_SLOT_EN keeps one sequential instruction alive after a redirect.
module estagio_busca
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [15:0] if_id_imm
);

`ifdef DELAY_SLOT_EN
  localparam logic DELAY_SLOT = 1'b1;
`else
  localparam logic DELAY_SLOT = 1'b0;
`endif

  fetch_state_t state;
  logic [31:0]  pc, pc_seq, redir_pc, buf_instr, buf_pc4;
  logic         redir_pending, drop_next;
  logic         ack_fire, can_accept, kill_seq, word_kept;
  logic         load_mem, load_buf, to_buffer, ifid_load, ifid_clear;
  logic [31:0]  ifid_instr_new, ifid_pc4_new;

  // imem_req comes straight from the state register, so an async reset drops it at once
  assign pc_seq     = pc + PC_STEP;
  assign imem_req   = (state == S_FETCH);
  assign imem_addr  = pc;
  assign ack_fire   = imem_req && imem_ack;
  assign can_accept = !stall || !if_id_valid;

  // kill_seq: the sequential word that is not yet in IF/ID must not get there
  assign kill_seq   = flush || (redirect && !DELAY_SLOT);
  assign word_kept  = ack_fire && !drop_next && !kill_seq;
  assign load_mem   = word_kept && can_accept;
  assign to_buffer  = word_kept && !can_accept;
  assign load_buf   = (state == S_FULL) && !stall && !kill_seq;

  assign ifid_load      = load_mem || load_buf;
  assign ifid_clear     = flush || (!stall && !ifid_load);
  assign ifid_instr_new = load_buf ? buf_instr : imem_rdata;
  assign ifid_pc4_new   = load_buf ? buf_pc4 : pc_seq;

  // A redirect that arrives during an outstanding request is parked in redir_pc so the
  // address seen by memory stays stable until the ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_BOOT;
      pc            <= RESET_PC;
      redir_pc      <= '0;
      redir_pending <= 1'b0;
      drop_next     <= 1'b0;
      buf_instr     <= NOP_INSTR;
      buf_pc4       <= '0;
    end else begin
      case (state)
        S_BOOT: begin
          state <= S_FETCH;
          if (redirect) pc <= redirect_pc;
        end
        S_FETCH: begin
          if (ack_fire) begin
            redir_pending <= 1'b0;
            drop_next     <= 1'b0;
            if (redirect)           pc <= redirect_pc;
            else if (redir_pending) pc <= redir_pc;
            else                    pc <= pc_seq;
            if (to_buffer) begin
              buf_instr <= imem_rdata;
              buf_pc4   <= pc_seq;
              state     <= S_FULL;
            end
          end else if (redirect) begin
            redir_pending <= 1'b1;
            redir_pc      <= redirect_pc;
            drop_next     <= !DELAY_SLOT;
          end
        end
        S_FULL: begin
          if (redirect) pc <= redirect_pc;
          if (kill_seq || !stall) state <= S_FETCH;
        end
        default: state <= S_BOOT;
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ifid_load),
    .clear     (ifid_clear),
    .new_instr (ifid_instr_new),
    .new_pc4   (ifid_pc4_new),
    .valid     (if_id_valid),
    .instr     (if_id_instr),
    .pc4       (if_id_pc4),
    .imm       (if_id_imm)
  );

endmodule

// File: tb/tb_estagio_busca.sv
// Directed self-checking bench for estagio_busca: streaming, stall buffering, redirect
// with a wait-state fetch, flush in S_FULL, pc wrap and asynchronous reset.
module tb_estagio_busca;

  logic        clk;
  logic        rst_n;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall, flush, redirect;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc4;
  logic [15:0] if_id_imm;

  logic        req2, ack2, valid2;
  logic [31:0] addr2, rdata2, instr2, pc42;
  logic [15:0] imm2;

  int          waits;
  int          wcnt;
  logic        ov_en;
  logic [31:0] ov_val;
  int          numChecks;
  int          numFails;

  estagio_busca #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_imm(if_id_imm)
  );

  // Second instance exercises the pc wrap from the top of the address space
  estagio_busca #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
    .stall(1'b0), .flush(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .if_id_valid(valid2), .if_id_instr(instr2), .if_id_pc4(pc42), .if_id_imm(imm2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack after 'waits' extra cycles, data = addr | A000_0000 unless overridden
  assign imem_ack   = imem_req && (wcnt >= waits);
  assign imem_rdata = ov_en ? ov_val : (imem_addr | 32'hA000_0000);
  assign ack2       = req2;
  assign rdata2     = addr2 | 32'hA000_0000;

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic f, input logic r, input logic [31:0] rpc);
    stall       = s;
    flush       = f;
    redirect    = r;
    redirect_pc = rpc;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    numChecks = 0;
    numFails  = 0;
    waits     = 0;
    wcnt      = 0;
    ov_en     = 1'b0;
    ov_val    = 32'h0;
    rst_n     = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);

    checkOutput("rst_req",   {31'b0, imem_req},    32'h0);
    checkOutput("rst_valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("rst_instr", if_id_instr,          32'h0);
    checkOutput("rst_pc4",   if_id_pc4,            32'h0);
    checkOutput("rst_imm",   {16'b0, if_id_imm},   32'h0);
    checkOutput("rst_req2",  {31'b0, req2},        32'h0);

    // Reset release and zero-wait streaming
    rst_n = 1'b1;
    tick();
    checkOutput("boot_req",   {31'b0, imem_req},    32'h1);
    checkOutput("boot_addr",  imem_addr,            32'h0);
    checkOutput("boot_valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("wrap_addr0", addr2,                32'hFFFF_FFFC);
    tick();
    checkOutput("s0_valid", {31'b0, if_id_valid}, 32'h1);
    checkOutput("s0_instr", if_id_instr,          32'hA000_0000);
    checkOutput("s0_pc4",   if_id_pc4,            32'h4);
    checkOutput("s0_addr",  imem_addr,            32'h4);
    checkOutput("wrap_addr1", addr2,              32'h0);
    checkOutput("wrap_pc4",   pc42,               32'h0);
    checkOutput("wrap_instr", instr2,             32'hFFFF_FFFC);
    tick();
    checkOutput("s1_instr", if_id_instr, 32'hA000_0004);
    checkOutput("s1_pc4",   if_id_pc4,   32'h8);
    tick();
    checkOutput("s2_instr", if_id_instr, 32'hA000_0008);
    checkOutput("s2_pc4",   if_id_pc4,   32'hC);
    checkOutput("s2_addr",  imem_addr,   32'hC);

    // Stall for three cycles while the 0xC fetch returns 2001_8000
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    ov_en  = 1'b1;
    ov_val = 32'h2001_8000;
    tick();
    checkOutput("stl_req",   {31'b0, imem_req}, 32'h0);
    checkOutput("stl_hold0", if_id_instr,       32'hA000_0008);
    tick();
    tick();
    checkOutput("stl_hold2", if_id_instr,          32'hA000_0008);
    checkOutput("stl_valid", {31'b0, if_id_valid}, 32'h1);
    checkOutput("stl_req2",  {31'b0, imem_req},    32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    ov_en = 1'b0;
    tick();
    checkOutput("rel_instr", if_id_instr,        32'h2001_8000);
    checkOutput("rel_imm",   {16'b0, if_id_imm}, 32'h0000_8000);
    checkOutput("rel_pc4",   if_id_pc4,          32'h10);
    checkOutput("rel_addr",  imem_addr,          32'h10);
    checkOutput("rel_req",   {31'b0, imem_req},  32'h1);

    // Redirect to 0x100 while a 2-wait-state fetch of 0x10 is outstanding
    waits = 2;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rd_addr0",  imem_addr,            32'h10);
    checkOutput("rd_req0",   {31'b0, imem_req},    32'h1);
    checkOutput("rd_valid0", {31'b0, if_id_valid}, 32'h0);
    tick();
    checkOutput("rd_addr1", imem_addr, 32'h10);
    tick();
`ifdef DELAY_SLOT_EN
    checkOutput("rd_slot_valid", {31'b0, if_id_valid}, 32'h1);
    checkOutput("rd_slot_instr", if_id_instr,          32'hA000_0010);
    checkOutput("rd_slot_pc4",   if_id_pc4,            32'h14);
`else
    checkOutput("rd_drop_valid", {31'b0, if_id_valid}, 32'h0);
`endif
    checkOutput("rd_target", imem_addr, 32'h100);
    waits = 0;
    tick();
    checkOutput("rd_instr", if_id_instr,          32'hA000_0100);
    checkOutput("rd_pc4",   if_id_pc4,            32'h104);
    checkOutput("rd_valid", {31'b0, if_id_valid}, 32'h1);

    // Flush together with stall while a word sits in the buffer
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("fl_full_req", {31'b0, imem_req}, 32'h0);
    checkOutput("fl_hold",     if_id_instr,       32'hA000_0100);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("fl_valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("fl_req",   {31'b0, imem_req},    32'h1);
    checkOutput("fl_addr",  imem_addr,            32'h108);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("fl_instr", if_id_instr,          32'hA000_0108);
    checkOutput("fl_pc4",   if_id_pc4,            32'h10C);
    checkOutput("fl_vnext", {31'b0, if_id_valid}, 32'h1);

    // Reset asserted in the middle of a wait-state fetch
    waits = 3;
    tick();
    checkOutput("mw_req",  {31'b0, imem_req}, 32'h1);
    checkOutput("mw_addr", imem_addr,         32'h10C);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_req",   {31'b0, imem_req},    32'h0);
    checkOutput("mr_valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("mr_instr", if_id_instr,          32'h0);
    checkOutput("mr_pc4",   if_id_pc4,            32'h0);
    checkOutput("mr_imm",   {16'b0, if_id_imm},   32'h0);
    checkOutput("mr_addr",  imem_addr,            32'h0);
    checkOutput("mr_req2",  {31'b0, req2},        32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
